ayatsuki_mem: RTL and testbench

AYATSUKI_MEM -- requirements
Module: ayatsuki_mem

---
 rtl/ayatsuki_mem_pkg.sv | 17 +
 rtl/ayatsuki_byte_ram.sv | 45 ++++
 rtl/ayatsuki_mem.sv | 136 +++++++++++++
 tb/tb_ayatsuki_mem.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ayatsuki_mem_pkg.sv
// Shared definitions for the ayatsuki boot/instruction/data memory block:
// bus widths, default sizes and the controller state encoding.
package ayatsuki_mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;

  localparam int unsigned     MEM_BYTES_DEF = 2048;
  localparam logic [XLEN-1:0] INST_NOP_DEF  = 32'h0000_0013;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2
  } state_e;

endpackage

// File: rtl/ayatsuki_byte_ram.sv
// Byte-addressed RAM with a combinational 4-byte big-endian read port,
// a 4-byte big-endian write port and a single-byte write port.
module ayatsuki_byte_ram
  import ayatsuki_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  localparam int unsigned AW = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [XLEN-1:0]   rd_data_o,
  input  logic              wr4_en_i,
  input  logic [AW-1:0]     wr4_addr_i,
  input  logic [XLEN-1:0]   wr4_data_i,
  input  logic              wr1_en_i,
  input  logic [AW-1:0]     wr1_addr_i,
  input  logic [BYTE_W-1:0] wr1_data_i
);

  logic [BYTE_W-1:0] mem [MEM_BYTES];
  logic [AW-1:0]     rd_idx [4];
  logic [AW-1:0]     wr_idx [4];

  // Lane indices wrap inside the array; callers gate out-of-range words.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_idx[i] = rd_addr_i + AW'(i);
      wr_idx[i] = wr4_addr_i + AW'(i);
    end
  end

  assign rd_data_o = {mem[rd_idx[0]], mem[rd_idx[1]], mem[rd_idx[2]], mem[rd_idx[3]]};

  always_ff @(posedge clk) begin
    if (wr4_en_i) begin
      for (int i = 0; i < 4; i++) begin
        mem[wr_idx[i]] <= wr4_data_i[BYTE_W*(3-i) +: BYTE_W];
      end
    end
    if (wr1_en_i) begin
      mem[wr1_addr_i] <= wr1_data_i;
    end
  end

endmodule

// File: rtl/ayatsuki_mem.sv
// Boot-loaded instruction store plus data store: clears both stores, accepts a
// byte stream into the instruction store, then releases the core and serves it.
module ayatsuki_mem
  import ayatsuki_mem_pkg::*;
#(
  parameter int unsigned     MEM_BYTES = MEM_BYTES_DEF,
  parameter logic [XLEN-1:0] INST_NOP  = INST_NOP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid_i,
  input  logic [BYTE_W-1:0] load_byte_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              core_rst_n_o,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic [XLEN-1:0]   inst_o,
  input  logic              mem_enable_i,
  input  logic              mem_r_enable_i,
  input  logic              mem_w_enable_i,
  input  logic [XLEN-1:0]   mem_r_addr_i,
  input  logic [XLEN-1:0]   mem_w_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  output logic [XLEN-1:0]   mem_data_o
);

  localparam int unsigned     AW        = $clog2(MEM_BYTES);
  localparam int unsigned     CW        = AW - 2;
  localparam logic [XLEN-1:0] ADDR_LIM  = XLEN'(MEM_BYTES - 4);
  localparam logic [CW-1:0]   CLR_LAST  = CW'(MEM_BYTES / 4 - 1);
  localparam logic [AW-1:0]   PTR_LAST  = AW'(MEM_BYTES - 1);

  state_e          state_q;
  logic [CW-1:0]   clr_cnt_q;
  logic [AW-1:0]   load_ptr_q;
  logic            core_rst_n_q;
  logic [XLEN-1:0] inst_q;

  logic            run;
  logic            clearing;
  logic [AW-1:0]   clr_addr;
  logic            fetch_ok;
  logic            rd_ok;
  logic            wr_ok;
  logic [XLEN-1:0] inst_rd;
  logic [XLEN-1:0] data_rd;
  logic            d_wr4_en;
  logic [AW-1:0]   d_wr4_addr;
  logic [XLEN-1:0] d_wr4_data;

  assign run      = (state_q == StRun);
  assign clearing = (state_q == StClear);
  assign clr_addr = {clr_cnt_q, 2'b00};

  assign fetch_ok = run && (inst_addr_i <= ADDR_LIM);
  assign rd_ok    = run && mem_enable_i && mem_r_enable_i && (mem_r_addr_i <= ADDR_LIM);
  assign wr_ok    = run && mem_enable_i && mem_w_enable_i && (mem_w_addr_i <= ADDR_LIM);

  // The data store's word write port is shared between the clear sweep and core stores.
  assign d_wr4_en   = clearing || wr_ok;
  assign d_wr4_addr = clearing ? clr_addr : mem_w_addr_i[AW-1:0];
  assign d_wr4_data = clearing ? '0 : mem_data_i;

  // Read is combinational off pre-edge contents, so a same-cycle write shows next cycle.
  assign mem_data_o   = rd_ok ? data_rd : '0;
  assign load_ready_o = (state_q == StLoad);
  assign core_rst_n_o = core_rst_n_q;
  assign inst_o       = inst_q;

  ayatsuki_byte_ram #(
    .MEM_BYTES (MEM_BYTES)
  ) u_inst_ram (
    .clk        (clk),
    .rd_addr_i  (inst_addr_i[AW-1:0]),
    .rd_data_o  (inst_rd),
    .wr4_en_i   (clearing),
    .wr4_addr_i (clr_addr),
    .wr4_data_i ('0),
    .wr1_en_i   (load_ready_o && load_valid_i),
    .wr1_addr_i (load_ptr_q),
    .wr1_data_i (load_byte_i)
  );

  ayatsuki_byte_ram #(
    .MEM_BYTES (MEM_BYTES)
  ) u_data_ram (
    .clk        (clk),
    .rd_addr_i  (mem_r_addr_i[AW-1:0]),
    .rd_data_o  (data_rd),
    .wr4_en_i   (d_wr4_en),
    .wr4_addr_i (d_wr4_addr),
    .wr4_data_i (d_wr4_data),
    .wr1_en_i   (1'b0),
    .wr1_addr_i ('0),
    .wr1_data_i ('0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StClear;
      clr_cnt_q    <= '0;
      load_ptr_q   <= '0;
      core_rst_n_q <= 1'b0;
      inst_q       <= INST_NOP;
    end else begin
      inst_q <= fetch_ok ? inst_rd : INST_NOP;
      case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + CW'(1);
          if (clr_cnt_q == CLR_LAST) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (load_valid_i) begin
            // The final slot ends the load even without a last marker; no wrap.
            if (load_last_i || (load_ptr_q == PTR_LAST)) begin
              state_q      <= StRun;
              core_rst_n_q <= 1'b1;
            end else begin
              load_ptr_q <= load_ptr_q + AW'(1);
            end
          end
        end
        StRun: begin
          core_rst_n_q <= 1'b1;
        end
        default: begin
          state_q      <= StClear;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ayatsuki_mem.sv
// Directed self-checking bench for ayatsuki_mem: clear, boot load, fetch,
// data port hazards and bounds, full-size stream and mid-run reset.
module tb_ayatsuki_mem;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        core_rst_n;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        mem_enable;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  ayatsuki_mem u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid_i   (load_valid),
    .load_byte_i    (load_byte),
    .load_last_i    (load_last),
    .load_ready_o   (load_ready),
    .core_rst_n_o   (core_rst_n),
    .inst_addr_i    (inst_addr),
    .inst_o         (inst),
    .mem_enable_i   (mem_enable),
    .mem_r_enable_i (mem_r_enable),
    .mem_w_enable_i (mem_w_enable),
    .mem_r_addr_i   (mem_r_addr),
    .mem_w_addr_i   (mem_w_addr),
    .mem_data_i     (mem_wdata),
    .mem_data_o     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  prog [8] = '{8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13};
  logic [31:0] acc;

  initial begin
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_byte    = '0;
    load_last    = 1'b0;
    inst_addr    = '0;
    mem_enable   = 1'b1;
    mem_r_enable = 1'b1;
    mem_w_enable = 1'b0;
    mem_r_addr   = '0;
    mem_w_addr   = '0;
    mem_wdata    = '0;

    repeat (3) step();
    check("rst_ready",    {31'b0, load_ready}, 32'd0);
    check("rst_core_rst", {31'b0, core_rst_n}, 32'd0);
    check("rst_inst",     inst, NOP);
    check("rst_rdata",    mem_rdata, 32'h0);

    rst_n = 1'b1;
    repeat (511) step();
    check("clear_511_ready", {31'b0, load_ready}, 32'd0);
    step();
    check("clear_512_ready", {31'b0, load_ready}, 32'd1);
    check("load_core_rst",   {31'b0, core_rst_n}, 32'd0);
    check("load_inst",       inst, NOP);

    repeat (20) step();
    check("load_idle_ready",    {31'b0, load_ready}, 32'd1);
    check("load_idle_core_rst", {31'b0, core_rst_n}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_byte  = prog[i];
      load_last  = (i == 7);
      if (i == 7) check("pre_last_core_rst", {31'b0, core_rst_n}, 32'd0);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("run_core_rst", {31'b0, core_rst_n}, 32'd1);
    check("run_ready",    {31'b0, load_ready}, 32'd0);

    inst_addr = 32'd4;
    step();
    check("fetch_4", inst, 32'h0010_0013);
    inst_addr = 32'd0;
    step();
    check("fetch_0", inst, 32'h0000_0093);

    mem_r_enable = 1'b0;
    mem_w_enable = 1'b1;
    mem_w_addr   = 32'd0;
    mem_wdata    = 32'hDEAD_BEEF;
    step();
    mem_w_enable = 1'b0;
    mem_r_enable = 1'b1;
    mem_r_addr   = 32'd1;
    #1 check("rd_unaligned_1", mem_rdata, 32'hADBE_EF00);
    mem_r_addr = 32'd0;
    #1 check("rd_aligned_0", mem_rdata, 32'hDEAD_BEEF);

    mem_r_addr   = 32'd8;
    mem_w_enable = 1'b1;
    mem_w_addr   = 32'd8;
    mem_wdata    = 32'h1234_5678;
    #1 check("rw_same_old", mem_rdata, 32'h0);
    step();
    mem_w_enable = 1'b0;
    #1 check("rw_same_new", mem_rdata, 32'h1234_5678);

    mem_w_enable = 1'b1;
    mem_w_addr   = 32'd2045;
    mem_wdata    = 32'hFFFF_FFFF;
    step();
    mem_w_enable = 1'b0;
    mem_r_addr   = 32'd2045;
    #1 check("rd_oob_2045", mem_rdata, 32'h0);
    mem_r_addr = 32'd2044;
    #1 check("rd_2044_untouched", mem_rdata, 32'h0);
    inst_addr = 32'd2046;
    step();
    check("fetch_oob_2046", inst, NOP);
    inst_addr = 32'd2044;
    step();
    check("fetch_2044_blank", inst, 32'h0);

    mem_enable = 1'b0;
    mem_r_addr = 32'd0;
    #1 check("rd_disabled", mem_rdata, 32'h0);
    mem_w_enable = 1'b1;
    mem_w_addr   = 32'd0;
    mem_wdata    = 32'h0;
    step();
    mem_w_enable = 1'b0;
    mem_enable   = 1'b1;
    #1 check("wr_disabled_ignored", mem_rdata, 32'hDEAD_BEEF);

    mem_w_enable = 1'b1;
    mem_w_addr   = 32'd100;
    mem_wdata    = 32'hCAFE_F00D;
    step();
    mem_w_enable = 1'b0;
    mem_r_addr   = 32'd100;
    #1 check("rd_100", mem_rdata, 32'hCAFE_F00D);

    rst_n = 1'b0;
    #1;
    check("midrun_rst_core_rst", {31'b0, core_rst_n}, 32'd0);
    check("midrun_rst_inst",     inst, NOP);
    check("midrun_rst_rdata",    mem_rdata, 32'h0);
    repeat (2) step();
    rst_n     = 1'b1;
    inst_addr = 32'd0;
    repeat (512) step();
    check("reclear_ready", {31'b0, load_ready}, 32'd1);

    for (int i = 0; i < 2048; i++) begin
      load_valid = 1'b1;
      load_byte  = i[7:0];
      load_last  = 1'b0;
      if (i == 2047) begin
        check("stream_pre_2047_ready",    {31'b0, load_ready}, 32'd1);
        check("stream_pre_2047_core_rst", {31'b0, core_rst_n}, 32'd0);
      end
      step();
    end
    load_valid = 1'b0;
    check("stream_run_core_rst", {31'b0, core_rst_n}, 32'd1);
    check("stream_run_ready",    {31'b0, load_ready}, 32'd0);

    inst_addr = 32'd2044;
    step();
    check("stream_fetch_2044", inst, 32'hFCFD_FEFF);
    inst_addr = 32'd1;
    step();
    check("stream_fetch_1", inst, 32'h0102_0304);

    acc = '0;
    for (int a = 0; a < 2048; a += 4) begin
      mem_r_addr = a;
      #1 acc |= mem_rdata;
    end
    check("dmem_cleared", acc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
